// File: rtl/gf180_ram_512x8_ctrl.sv
// 32-bit word request/response front end for a 512x8 GF180 SRAM macro; each word is moved as four byte accesses.
// Optional feature RAM_CTRL_WSKIP_EN: write bytes whose strobe is clear are skipped instead of spending an idle cycle.
module gf180_ram_512x8_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        ram_cen,
  output logic        ram_gwen,
  output logic [8:0]  ram_a,
  output logic [7:0]  ram_d,
  output logic [7:0]  ram_wen,
  input  logic [7:0]  ram_q
);

  // state   | meaning
  // IDLE    | waiting for a request; req_ready=1
  // ACCESS  | presenting byte k to the SRAM
  // CAPTURE | collecting the last read byte from ram_q
  // RESP    | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  k;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic        cap_pend;
  logic [1:0]  cap_idx;
  logic        accept;
  logic        last_byte;
  logic [2:0]  k_ext_nxt;
  logic [2:0]  start_ext;

  // Lowest set bit of mask at or above index from; 4 when there is none.
  function automatic logic [2:0] next_set(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(from) && mask[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    k_ext_nxt = {1'b0, k} + 3'd1;
    start_ext = 3'd0;
`ifdef RAM_CTRL_WSKIP_EN
    if (we_q) k_ext_nxt = next_set(wstrb_q, {1'b0, k} + 3'd1);
    if (req_we) start_ext = next_set(req_wstrb, 3'd0);
`else
    if (req_we) start_ext = 3'd0;
`endif
  end

  assign last_byte = k_ext_nxt[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ACCESS;
      ACCESS:  if (last_byte) state_nxt = we_q ? RESP : CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    ram_cen   = 1'b1;
    ram_gwen  = 1'b1;
    ram_wen   = 8'hFF;
    ram_a     = 9'd0;
    ram_d     = 8'd0;
    if (state == ACCESS) begin
      ram_a = {addr_q, k};
      ram_d = wdata_q[{k, 3'b000} +: 8];
      if (!we_q) begin
        ram_cen = 1'b0;
      end else if (wstrb_q[k]) begin
        ram_cen  = 1'b0;
        ram_gwen = 1'b0;
        ram_wen  = 8'h00;
      end
    end
  end

  // Read data for byte k appears on ram_q one edge after it was issued, so capture lags by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k         <= 2'd0;
      addr_q    <= 7'd0;
      we_q      <= 1'b0;
      wstrb_q   <= 4'd0;
      wdata_q   <= 32'd0;
      cap_pend  <= 1'b0;
      cap_idx   <= 2'd0;
      rsp_rdata <= 32'd0;
    end else begin
      cap_pend <= 1'b0;
      if (cap_pend) rsp_rdata[{cap_idx, 3'b000} +: 8] <= ram_q;
      if (accept) begin
        addr_q    <= req_addr;
        we_q      <= req_we;
        wstrb_q   <= req_wstrb;
        wdata_q   <= req_wdata;
        k         <= start_ext[1:0];
        rsp_rdata <= 32'd0;
      end else if (state == ACCESS) begin
        k <= k_ext_nxt[1:0];
        if (!we_q) begin
          cap_pend <= 1'b1;
          cap_idx  <= k;
        end
      end
    end
  end

endmodule

// File: tb/tb_gf180_ram_512x8_ctrl.sv
// Randomized self-checking bench for gf180_ram_512x8_ctrl with a byte-array SRAM model and a word-level reference.
// Expected write latency follows RAM_CTRL_WSKIP_EN when the bench is built with it.
module tb_gf180_ram_512x8_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_addr;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        ram_cen;
  logic        ram_gwen;
  logic [8:0]  ram_a;
  logic [7:0]  ram_d;
  logic [7:0]  ram_wen;
  logic [7:0]  ram_q = 8'd0;

  logic [7:0]  sram    [512];
  logic [7:0]  ref_mem [512];
  logic        mem_load;
  logic [9:0]  mon_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  gf180_ram_512x8_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_a(ram_a), .ram_d(ram_d),
    .ram_wen(ram_wen), .ram_q(ram_q)
  );

  // SRAM macro model: per-bit write enable, registered read data.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 512; i++) sram[i] <= ref_mem[i];
    end else if (!ram_cen) begin
      if (!ram_gwen) sram[ram_a] <= (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else           ram_q <= sram[ram_a];
    end
  end

  always @(posedge clk) begin
    if (!ram_cen) mon_q.push_back({~ram_gwen, ram_a});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_txn(input logic [6:0] a, input logic we, input logic [3:0] st,
                        input logic [31:0] wd, input int hold, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic [9:0]  exp_acc [$];
    logic [8:0]  ba;
    int          exp_lat, lat, n;
    n = 0;
    exp_rd = 32'd0;
    for (int b = 0; b < 4; b++) begin
      ba = {a, 2'(b)};
      if (!we) begin
        exp_rd[8*b +: 8] = ref_mem[ba];
        exp_acc.push_back({1'b0, ba});
      end else if (st[b]) begin
        n++;
        exp_acc.push_back({1'b1, ba});
      end
    end
    exp_lat = we ? 4 : 5;
`ifdef RAM_CTRL_WSKIP_EN
    if (we) exp_lat = (n == 0) ? 1 : n;
`endif
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_wstrb = st;
    req_wdata = wd;
    rsp_ready = (hold == 0);
    mon_q.delete();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 7'($urandom);
    req_we    = 1'($urandom);
    req_wstrb = 4'($urandom);
    req_wdata = $urandom;
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_latency", lat, exp_lat);
    check("rsp_rdata", rsp_rdata, exp_rd);
    rd = rsp_rdata;
    check("access_count", mon_q.size(), exp_acc.size());
    for (int i = 0; i < exp_acc.size(); i++) begin
      if (i < mon_q.size()) check("access_seq", {22'd0, mon_q[i]}, {22'd0, exp_acc[i]});
    end
    if (we) begin
      for (int b = 0; b < 4; b++) if (st[b]) ref_mem[{a, 2'(b)}] = wd[8*b +: 8];
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("hold_cen", {31'd0, ram_cen}, 32'd1);
    end
    if (hold > 0) begin
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_cen"}, {31'd0, ram_cen}, 32'd1);
    check({tag, "_gwen"}, {31'd0, ram_gwen}, 32'd1);
    check({tag, "_wen"}, {24'd0, ram_wen}, 32'hFF);
    check({tag, "_a"}, {23'd0, ram_a}, 32'd0);
    check({tag, "_d"}, {24'd0, ram_d}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] wd;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 7'd0;
    req_we    = 1'b0;
    req_wstrb = 4'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b1;
    mem_load  = 1'b1;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    mem_load = 1'b0;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    do_txn(7'h05, 1'b1, 4'hF, 32'hDEADBEEF, 0, rd);
    check("w050_rdata_zero", rd, 32'd0);
    check("w050_byte14", {24'd0, sram[9'h014]}, 32'hEF);
    check("w050_byte15", {24'd0, sram[9'h015]}, 32'hBE);
    check("w050_byte16", {24'd0, sram[9'h016]}, 32'hAD);
    check("w050_byte17", {24'd0, sram[9'h017]}, 32'hDE);

    do_txn(7'h05, 1'b0, 4'h0, 32'd0, 0, rd);
    check("r051_rdata", rd, 32'hDEADBEEF);

    do_txn(7'h05, 1'b1, 4'b0101, 32'h11223344, 0, rd);
    do_txn(7'h05, 1'b0, 4'h0, 32'd0, 0, rd);
    check("r052_rdata", rd, 32'hDE22BE44);

    do_txn(7'h05, 1'b0, 4'h0, 32'd0, 10, rd);

    // Reset lands just after the second byte of a write has been committed.
    wd = $urandom;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 7'h7F;
    req_we    = 1'b1;
    req_wstrb = 4'hF;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_cen", {31'd0, ram_cen}, 32'd1);
    ref_mem[9'h1FC] = wd[7:0];
    ref_mem[9'h1FD] = wd[15:8];
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);
    check("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_byte1fe", {24'd0, sram[9'h1FE]}, {24'd0, ref_mem[9'h1FE]});
    check("rst_byte1ff", {24'd0, sram[9'h1FF]}, {24'd0, ref_mem[9'h1FF]});
    check("rst_byte1fd", {24'd0, sram[9'h1FD]}, {24'd0, wd[15:8]});

    do_txn(7'h00, 1'b0, 4'h0, 32'd0, 0, rd);
    do_txn(7'h7F, 1'b0, 4'h0, 32'd0, 0, rd);

    for (int t = 0; t < 60; t++) begin
      do_txn(7'($urandom), 1'($urandom), 4'($urandom), $urandom,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, rd);
    end

    for (int i = 0; i < 512; i++) check("final_mem", {24'd0, sram[i]}, {24'd0, ref_mem[i]});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
